// File: rtl/fpu_mul_unit.sv
// fpu_mul_unit: shift-add FP multiplier, normalise, ovf/unf flush; FPU_MUL_RNE_EN selects RNE, else truncate.
// Latency: out_valid F+2 edges after the accepting edge; one operation in flight.
// Backpressure: result and flags held in DONE until out_ready; in_ready only in IDLE.
module fpu_mul_unit #(
  parameter int E    = 8,
  parameter int F    = 23,
  parameter int BIAS = (1 << (E - 1)) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         a_sign,
  input  logic [E-1:0] a_exponent,
  input  logic [F:0]   a_fraction,
  input  logic         b_sign,
  input  logic [E-1:0] b_exponent,
  input  logic [F:0]   b_fraction,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         result_s,
  output logic [E-1:0] result_e,
  output logic [F:0]   result_f,
  output logic         flag_ovf,
  output logic         flag_unf
);
  localparam int CW = $clog2(F + 1);
  localparam int XW = E + 2;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [F:0]     mcand_q, hi_q, lo_q;
  logic [F+1:0]   step_sum;
  logic           sign_q, zero_q;
  logic [E-1:0]   ae_q, be_q;
  logic           accept;
  logic [2*F+1:0] prod;
  logic [XW-1:0]  exp_n, exp_fin;
  logic [F:0]     frac_n, frac_fin;
  logic           is_ovf, is_unf;
`ifdef FPU_MUL_RNE_EN
  logic           guard, rnd, sticky;
  logic [F+1:0]   frac_rnd;
`endif

  assign in_ready = rst_n && (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     if (cnt_q == CW'(F)) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Classic right-shifting product: low product bits replace consumed multiplier bits in lo_q.
  assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(F+2){1'b0}});
  assign prod     = {hi_q, lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      ae_q    <= '0;
      be_q    <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      mcand_q <= a_fraction;
      hi_q    <= '0;
      lo_q    <= b_fraction;
      sign_q  <= a_sign ^ b_sign;
      zero_q  <= (a_fraction == '0) || (b_fraction == '0);
      ae_q    <= a_exponent;
      be_q    <= b_exponent;
    end else if (state_q == MUL) begin
      cnt_q        <= cnt_q + CW'(1);
      {hi_q, lo_q} <= {step_sum, lo_q[F:1]};
    end
  end

  always_comb begin
    exp_n    = {2'b00, ae_q} + {2'b00, be_q} - XW'(BIAS);
    frac_n   = prod[2*F:F];
    frac_fin = '0;
    exp_fin  = '0;
    if (prod[2*F+1]) begin
      frac_n = prod[2*F+1:F+1];
      exp_n  = exp_n + XW'(1);
    end
`ifdef FPU_MUL_RNE_EN
    guard    = prod[2*F+1] ? prod[F]       : prod[F-1];
    rnd      = prod[2*F+1] ? prod[F-1]     : prod[F-2];
    sticky   = prod[2*F+1] ? |prod[F-2:0]  : |prod[F-3:0];
    frac_rnd = {1'b0, frac_n} + (F+2)'(guard && (rnd || sticky || frac_n[0]));
    if (frac_rnd[F+1]) begin
      frac_fin = frac_rnd[F+1:1];
      exp_fin  = exp_n + XW'(1);
    end else begin
      frac_fin = frac_rnd[F:0];
      exp_fin  = exp_n;
    end
`else
    frac_fin = frac_n;
    exp_fin  = exp_n;
`endif
  end

  // exp_fin is two's complement in XW bits; the top bit marks a negative sum.
  assign is_ovf = !exp_fin[XW-1] && (exp_fin >= XW'((1 << E) - 1));
  assign is_unf = exp_fin[XW-1] || (exp_fin == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result_s  <= 1'b0;
      result_e  <= '0;
      result_f  <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
    end else if (state_q == NORM) begin
      out_valid <= 1'b1;
      result_s  <= sign_q;
      result_e  <= '0;
      result_f  <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      if (zero_q) begin
        result_e <= '0;
      end else if (is_ovf) begin
        result_e <= '1;
        flag_ovf <= 1'b1;
      end else if (is_unf) begin
        flag_unf <= 1'b1;
      end else begin
        result_e <= exp_fin[E-1:0];
        result_f <= frac_fin;
      end
    end else if ((state_q == DONE) && out_ready) begin
      out_valid <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
    end
  end

endmodule
